i2c_codec_slave: RTL and testbench
==================================

I2C_CODEC_SLAVE -- requirements
Module: i2c_codec_slave

Interface
- REQ-001: Parameter DEV_ADDR, default 7'b0011010, SHALL set the 7-bit device address the block responds to.
- REQ-002: Parameter NREG, default 10, SHALL set the number of shadow registers (R0..R9).
- REQ-003: clk  in  1  single system clock; all logic SHALL update on posedge clk.
- REQ-004: reset  in  1  synchronous, active-low reset.
- REQ-005: scl  in  1  I2C clock from the bus master; asynchronous to clk.
- REQ-006: sda_in  in  1  sampled SDA line level; asynchronous to clk.
- REQ-007: sda_oe  out  1  1 = pull SDA low (ACK); 0 = release the line.
- REQ-008: wr_valid  out  1  one-clk strobe marking a completed register write.
- REQ-009: wr_reg  out  7  register address of the last write; held until the next write.
- REQ-010: wr_data  out  9  9-bit data of the last write; held until the next write.
- REQ-011: busy  out  1  high from a START until the block returns to IDLE.
- REQ-012: rd_addr  in  4  shadow-register read index.
- REQ-013: rd_data  out  9  shadow register[rd_addr], combinational; reads 0 when rd_addr >= NREG.

Function
- REQ-014: scl and sda_in SHALL pass through 2-flop synchronizers; edge detection SHALL use the synchronized values. Pin-to-detect latency is 3 clk.
- REQ-015: START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both are detected in every state.
- REQ-016: Data bits SHALL be sampled MSB-first on the detected SCL rise, into an 8-bit shift register with a 3-bit bit counter.
- REQ-017: FSM states: IDLE, ADDR, ACK0, BYTE1, ACK1, BYTE2, ACK2, WAIT_STOP.
  - START from any state goes to ADDR and clears the bit counter.
  - STOP from any state goes to IDLE.
- REQ-018: ADDR, after 8 bits:
  - If byte[7:1]==DEV_ADDR and byte[0]==0, go to ACK0.
  - Otherwise go to WAIT_STOP with sda_oe held 0.
- REQ-019: ACK states:
  - sda_oe SHALL assert on the SCL fall that ends the 8th bit.
  - sda_oe SHALL deassert on the next SCL fall, then move to the next byte state.
- REQ-020: BYTE1 SHALL capture reg = byte[7:1] and data bit 8 = byte[0]. BYTE2 SHALL capture data[7:0].
- REQ-021: Commit happens in the clk where ACK2 sda_oe first asserts:
  - wr_valid = 1 for exactly that clk.
  - wr_reg and wr_data update in the same clk.
  - The shadow bank updates and is visible on rd_data the next clk.
- REQ-022: After ACK2 the FSM goes to WAIT_STOP. Further bytes SHALL be NACKed (sda_oe stays 0) and SHALL NOT commit.
- REQ-023: Bank update rules:
  - wr_reg < NREG: write register[wr_reg].
  - wr_reg == 7'h0F: load every register with its default (codec reset).
  - Any other address: no bank change, but wr_valid still pulses.
- REQ-024: STOP or repeated START before ACK2 SHALL abort the transfer:
  - no wr_valid, no bank change;
  - sda_oe SHALL be 0 the next clk.
- REQ-025: Simultaneous START/STOP detection and SCL edge: START/STOP takes priority and the bit is discarded.
- REQ-026: Operating condition: clk >= 16x SCL frequency; behaviour below that rate is undefined.

Reset
- REQ-027: reset low SHALL, on the next posedge clk, set:
  - FSM to IDLE;
  - sda_oe, wr_valid, busy = 0;
  - wr_reg, wr_data, counters, shift register = 0;
  - synchronizer flops = 1.
- REQ-028: Reset SHALL load shadow defaults: R0=0x097, R1=0x097, R2=0x079, R3=0x079, R4=0x00A, R5=0x008, R6=0x09F, R7=0x00A, R8=0x000, R9=0x000.
- REQ-029: Reset asserted mid-transfer SHALL release SDA within 1 clk and SHALL NOT commit a write.

Structure
- REQ-030: Package i2c_codec_pkg SHALL hold DEV_ADDR_DEFAULT, RESET_REG (7'h0F), the FSM state encoding, and the shadow default table.
- REQ-031: Sub-module i2c_line_sync SHALL contain the two synchronizers and the SCL rise/fall and START/STOP detectors. The top module holds the FSM and the bank.

Verification
- REQ-032: Bytes 0x34, 0x08, 0xF5, then STOP:
  - ACK on all 3 bytes;
  - one wr_valid with wr_reg=0x04, wr_data=0x0F5;
  - rd_addr=4 reads 0x0F5.
- REQ-033: Bytes 0x36, 0x08, 0xF5: sda_oe never asserts, no wr_valid, bank unchanged.
- REQ-034: Write R2=0x065, then bytes 0x34, 0x1E, 0x00:
  - wr_valid with wr_reg=0x0F;
  - all registers return to defaults (rd_addr=2 reads 0x079).
- REQ-035: Bytes 0x34, 0x0C, then STOP (or repeated START followed by a valid write):
  - no commit for the aborted frame;
  - the subsequent frame commits normally.
- REQ-036: Bytes 0x34, 0x0E, 0x52, 0xAA:
  - commit of reg 0x07 = 0x052;
  - 4th byte NACKed;
  - busy clears on STOP.
- REQ-037: reset pulsed during ACK1: sda_oe=0 the next clk, no wr_valid, bank at defaults.

Source files
------------

// File: rtl/i2c_codec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_codec_pkg
// Description : Shared constants, FSM state encoding and shadow defaults for
//               the I2C codec register slave.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_codec_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b0011010;
    localparam logic [6:0] RESET_REG        = 7'h0F;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_ADDR      = 3'd1;
    localparam logic [2:0] c_ST_ACK0      = 3'd2;
    localparam logic [2:0] c_ST_BYTE1     = 3'd3;
    localparam logic [2:0] c_ST_ACK1      = 3'd4;
    localparam logic [2:0] c_ST_BYTE2     = 3'd5;
    localparam logic [2:0] c_ST_ACK2      = 3'd6;
    localparam logic [2:0] c_ST_WAIT_STOP = 3'd7;

    function automatic logic [8:0] shadow_default(input int idx);
        logic [8:0] v;
        case (idx)
            0, 1:    v = 9'h097;
            2, 3:    v = 9'h079;
            4:       v = 9'h00A;
            5:       v = 9'h008;
            6:       v = 9'h09F;
            7:       v = 9'h00A;
            default: v = 9'h000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_sync
// Description : SCL/SDA synchronizers plus registered SCL edge and
//               START/STOP condition strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;
    logic r_scl_rise, r_scl_fall, r_start, r_stop;

    // Strobes are registered so r_sda_d lines up with the data bit they qualify.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_d    <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_s1   <= scl;
            r_scl_s2   <= r_scl_s1;
            r_scl_d    <= r_scl_s2;
            r_sda_s1   <= sda_in;
            r_sda_s2   <= r_sda_s1;
            r_sda_d    <= r_sda_s2;
            r_scl_rise <= r_scl_s2 & ~r_scl_d;
            r_scl_fall <= ~r_scl_s2 & r_scl_d;
            r_start    <= r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
            r_stop     <= r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
        end
    end

    assign scl_rise  = r_scl_rise;
    assign scl_fall  = r_scl_fall;
    assign start_det = r_start;
    assign stop_det  = r_stop;
    assign sda_bit   = r_sda_d;

endmodule
`default_nettype wire

// File: rtl/i2c_codec_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_codec_slave
// Description : Write-only I2C slave for a codec: 7-bit register address plus
//               9-bit data per frame, mirrored into a shadow register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_codec_slave
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int         NREG     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [6:0] wr_reg,
    output logic [8:0] wr_data,
    output logic       busy,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data
);

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_bit, w_shifting;
    logic [2:0] r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_byte_done;
    logic       r_sda_oe, r_wr_valid, r_busy, r_d8;
    logic [6:0] r_reg, r_wr_reg;
    logic [8:0] r_wr_data;
    logic [8:0] r_bank [0:NREG-1];

    i2c_line_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda_in    (sda_in),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_bit   (w_sda_bit)
    );

    assign w_shifting = (r_state == c_ST_ADDR)  || (r_state == c_ST_BYTE1) ||
                        (r_state == c_ST_BYTE2) || (r_state == c_ST_WAIT_STOP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_byte_done <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_d8        <= 1'b0;
            r_reg       <= '0;
            r_wr_reg    <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            // Bus conditions override any SCL edge seen in the same clk.
            if (w_start || w_stop) begin
                r_state     <= w_start ? c_ST_ADDR : c_ST_IDLE;
                r_busy      <= w_start;
                r_bitcnt    <= '0;
                r_byte_done <= 1'b0;
                r_sda_oe    <= 1'b0;
            end else if (w_scl_rise && w_shifting) begin
                r_shift  <= {r_shift[6:0], w_sda_bit};
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7)
                    r_byte_done <= 1'b1;
            end else if (w_scl_fall && r_byte_done) begin
                r_byte_done <= 1'b0;
                case (r_state)
                    c_ST_ADDR: begin
                        if (r_shift[7:1] == DEV_ADDR && !r_shift[0]) begin
                            r_state  <= c_ST_ACK0;
                            r_sda_oe <= 1'b1;
                        end else begin
                            r_state  <= c_ST_WAIT_STOP;
                        end
                    end
                    c_ST_BYTE1: begin
                        r_reg    <= r_shift[7:1];
                        r_d8     <= r_shift[0];
                        r_state  <= c_ST_ACK1;
                        r_sda_oe <= 1'b1;
                    end
                    c_ST_BYTE2: begin
                        r_state    <= c_ST_ACK2;
                        r_sda_oe   <= 1'b1;
                        r_wr_valid <= 1'b1;
                        r_wr_reg   <= r_reg;
                        r_wr_data  <= {r_d8, r_shift};
                    end
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                case (r_state)
                    c_ST_ACK0: begin r_state <= c_ST_BYTE1;     r_sda_oe <= 1'b0; end
                    c_ST_ACK1: begin r_state <= c_ST_BYTE2;     r_sda_oe <= 1'b0; end
                    c_ST_ACK2: begin r_state <= c_ST_WAIT_STOP; r_sda_oe <= 1'b0; end
                    default: ;
                endcase
            end
        end
    end

    // Bank follows the commit strobe by one clk.
    generate
        for (genvar i = 0; i < NREG; i++) begin : g_bank
            always_ff @(posedge clk) begin
                if (!reset)
                    r_bank[i] <= shadow_default(i);
                else if (r_wr_valid && r_wr_reg == RESET_REG)
                    r_bank[i] <= shadow_default(i);
                else if (r_wr_valid && r_wr_reg == 7'(i))
                    r_bank[i] <= r_wr_data;
            end
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < NREG)
            rd_data = r_bank[rd_addr];
    end

    assign sda_oe   = r_sda_oe;
    assign wr_valid = r_wr_valid;
    assign wr_reg   = r_wr_reg;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_codec_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_codec_slave
// Description : Directed bench driving I2C frames into i2c_codec_slave.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_codec_slave;

    localparam int c_Q = 100;   // quarter SCL period: 10 clk

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_in;
    logic       sda_oe, wr_valid, busy;
    logic [6:0] wr_reg;
    logic [8:0] wr_data;
    logic [3:0] rd_addr = 4'd0;
    logic [8:0] rd_data;

    int checks = 0;
    int errors = 0;
    int wv_pulses = 0;
    int wv_cycles = 0;
    logic wv_prev = 1'b0;
    logic a0, a1, a2, a3;

    assign sda_in = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_codec_slave dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_reg   (wr_reg),
        .wr_data  (wr_data),
        .busy     (busy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always @(negedge clk) begin
        if (wr_valid === 1'b1) wv_cycles++;
        if (wr_valid === 1'b1 && wv_prev !== 1'b1) wv_pulses++;
        wv_prev = wr_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input string tag, input logic [8:0] exp);
        rd_addr = a;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; #c_Q;
        scl = 1'b1;     #c_Q;
        sda_drv = 1'b0; #c_Q;
        scl = 1'b0;     #c_Q;
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; #c_Q;
        scl = 1'b1;     #c_Q;
        sda_drv = 1'b1; #(2*c_Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = b[i]; #c_Q;
            scl = 1'b1;     #(2*c_Q);
            scl = 1'b0;     #c_Q;
        end
    endtask

    task automatic ack_clock(output logic ack);
        sda_drv = 1'b1; #c_Q;
        scl = 1'b1;     #c_Q;
        ack = sda_oe;   #c_Q;
        scl = 1'b0;     #c_Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        ack_clock(ack);
    endtask

    initial begin
        // Reset state and default bank
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_reg", 32'(wr_reg), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b1;
        rd(4'd0, "def_r0", 9'h097);
        rd(4'd6, "def_r6", 9'h09F);
        rd(4'd9, "def_r9", 9'h000);
        rd(4'd12, "rd_oob", 9'h000);
        #(2*c_Q);

        // Basic write R4 = 0x0F5
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'hF5, a2);
        check("w1_acks", 32'({a0, a1, a2}), 32'b111);
        check("w1_busy", 32'(busy), 32'd1);
        i2c_stop();
        check("w1_pulses", 32'(wv_pulses), 32'd1);
        check("w1_wr_reg", 32'(wr_reg), 32'h04);
        check("w1_wr_data", 32'(wr_data), 32'h0F5);
        check("w1_busy_clr", 32'(busy), 32'd0);
        rd(4'd4, "w1_r4", 9'h0F5);

        // Wrong address: no ACK, no commit
        i2c_start();
        send_byte(8'h36, a0); send_byte(8'h08, a1); send_byte(8'hF5, a2);
        check("na_acks", 32'({a0, a1, a2}), 32'b000);
        i2c_stop();
        check("na_pulses", 32'(wv_pulses), 32'd1);
        rd(4'd4, "na_r4", 9'h0F5);

        // R2 = 0x065 then codec reset via register 0x0F
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h04, a1); send_byte(8'h65, a2);
        i2c_stop();
        rd(4'd2, "w2_r2", 9'h065);
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2);
        i2c_stop();
        check("cr_pulses", 32'(wv_pulses), 32'd3);
        check("cr_wr_reg", 32'(wr_reg), 32'h0F);
        rd(4'd2, "cr_r2", 9'h079);
        rd(4'd4, "cr_r4", 9'h00A);

        // Aborted frames: STOP, then repeated START into a valid write
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h0C, a1);
        i2c_stop();
        check("ab_stop_pulses", 32'(wv_pulses), 32'd3);
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h0C, a1);
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h0C, a1); send_byte(8'h33, a2);
        check("ab_rs_acks", 32'({a0, a1, a2}), 32'b111);
        i2c_stop();
        check("ab_rs_pulses", 32'(wv_pulses), 32'd4);
        rd(4'd6, "ab_rs_r6", 9'h033);

        // Extra byte after commit is NACKed
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h0E, a1);
        send_byte(8'h52, a2); send_byte(8'hAA, a3);
        check("xb_acks", 32'({a0, a1, a2, a3}), 32'b1110);
        check("xb_busy", 32'(busy), 32'd1);
        i2c_stop();
        check("xb_pulses", 32'(wv_pulses), 32'd5);
        check("xb_wr_reg", 32'(wr_reg), 32'h07);
        check("xb_wr_data", 32'(wr_data), 32'h052);
        check("xb_busy_clr", 32'(busy), 32'd0);
        rd(4'd7, "xb_r7", 9'h052);

        // Reset while ACK1 is driving SDA
        i2c_start();
        send_byte(8'h34, a0);
        send_bits(8'h10);
        check("rs_ack1_on", 32'(sda_oe), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rs_sda_oe", 32'(sda_oe), 32'd0);
        check("rs_wr_valid", 32'(wr_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        i2c_stop();
        check("rs_pulses", 32'(wv_pulses), 32'd5);
        check("rs_wr_reg", 32'(wr_reg), 32'h00);
        rd(4'd6, "rs_r6", 9'h09F);
        rd(4'd7, "rs_r7", 9'h00A);
        check("wv_one_clk", 32'(wv_cycles), 32'(wv_pulses));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
